// File: rtl/hazard_pipe_regs_pkg.sv
// Shared constants and tuple types for the D->E->M->W write-back metadata chain.
// Also imported by stallctrl for REG_ZERO.
package hazard_pipe_regs_pkg;

   localparam int          TNEW_W    = 2;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [31:0] BUBBLE_PC = 32'h0;
   localparam logic [4:0]  REG_ZERO  = 5'd0;

   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0]       instr;
      logic              regw;
      logic [4:0]        regwa;
      logic [TNEW_W-1:0] tnew;
   } stage_t;

   // W results are always forwardable, so the W tuple has no Tnew field.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        regw;
      logic [4:0]  regwa;
   } wb_t;

   localparam stage_t STAGE_BUBBLE = '{pc: BUBBLE_PC, instr: NOP_INSTR, regw: 1'b0,
                                       regwa: REG_ZERO, tnew: '0};
   localparam wb_t    WB_BUBBLE    = '{pc: BUBBLE_PC, instr: NOP_INSTR, regw: 1'b0,
                                       regwa: REG_ZERO};

   function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
      return (t != '0) ? t - TNEW_W'(1) : '0;
   endfunction

endpackage

// File: rtl/hazard_pipe_regs_pipe_stage.sv
// One pipeline register for a stage tuple; latency 1 cycle.
// No backpressure: clear_i loads a bubble instead of the incoming tuple.
module pipe_stage
   import hazard_pipe_regs_pkg::*;
#(
   parameter type T      = stage_t,
   parameter T    BUBBLE = T'('0)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  T     d_i,
   output T     q_o
);

   T q_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= T'('0);
      end else if (clear_i) begin
         q_q <= BUBBLE;
      end else begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// D->E->M->W register chain carrying write-back metadata with Tnew ageing; 1/2/3 cycles to E/M/W.
// No backpressure: isStall injects a bubble into E while older stages keep draining.
module hazard_pipe_regs
   import hazard_pipe_regs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              isStall,
   input  logic [31:0]       D_pc,
   input  logic [31:0]       D_instr,
   input  logic              D_regW,
   input  logic [4:0]        D_regWa,
   input  logic [TNEW_W-1:0] D_Tnew,
   output logic [31:0]       E_pc,
   output logic [31:0]       M_pc,
   output logic [31:0]       W_pc,
   output logic [31:0]       E_instr,
   output logic [31:0]       M_instr,
   output logic [31:0]       W_instr,
   output logic              E_regW,
   output logic              M_regW,
   output logic              W_regW,
   output logic [4:0]        E_regWa,
   output logic [4:0]        M_regWa,
   output logic [4:0]        W_regWa,
   output logic [TNEW_W-1:0] E_Tnew,
   output logic [TNEW_W-1:0] M_Tnew,
   output logic [CNT_W-1:0]  bubbleCnt
);

   stage_t           d_san;
   stage_t           e_q;
   stage_t           m_d;
   stage_t           m_q;
   wb_t              w_d;
   wb_t              w_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A write to $0 must never look like a pending write to the hazard logic.
   always_comb begin
      d_san       = STAGE_BUBBLE;
      d_san.pc    = D_pc;
      d_san.instr = D_instr;
      d_san.regw  = D_regW && (D_regWa != REG_ZERO);
      d_san.regwa = d_san.regw ? D_regWa : REG_ZERO;
      d_san.tnew  = D_Tnew;
   end

   always_comb begin
      m_d      = e_q;
      m_d.tnew = age_tnew(e_q.tnew);
   end

   assign w_d = '{pc: m_q.pc, instr: m_q.instr, regw: m_q.regw, regwa: m_q.regwa};

   pipe_stage #(.T(stage_t), .BUBBLE(STAGE_BUBBLE)) u_e (
      .clk(clk), .reset(reset), .clear_i(isStall), .d_i(d_san), .q_o(e_q)
   );

   pipe_stage #(.T(stage_t), .BUBBLE(STAGE_BUBBLE)) u_m (
      .clk(clk), .reset(reset), .clear_i(1'b0), .d_i(m_d), .q_o(m_q)
   );

   pipe_stage #(.T(wb_t), .BUBBLE(WB_BUBBLE)) u_w (
      .clk(clk), .reset(reset), .clear_i(1'b0), .d_i(w_d), .q_o(w_q)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (isStall && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign E_pc      = e_q.pc;
   assign E_instr   = e_q.instr;
   assign E_regW    = e_q.regw;
   assign E_regWa   = e_q.regwa;
   assign E_Tnew    = e_q.tnew;
   assign M_pc      = m_q.pc;
   assign M_instr   = m_q.instr;
   assign M_regW    = m_q.regw;
   assign M_regWa   = m_q.regwa;
   assign M_Tnew    = m_q.tnew;
   assign W_pc      = w_q.pc;
   assign W_instr   = w_q.instr;
   assign W_regW    = w_q.regw;
   assign W_regWa   = w_q.regwa;
   assign bubbleCnt = cnt_q;

endmodule
